ddr2_mem_responder_model: RTL

Behavioural responder for the 256-bit cache-to-DDR2 command interface. It is the memory side of the link that the instruction/data cache dummies drive. It accepts one read or write command at a time, holds it for a programmable latency, and then pulses ready. Write data is committed to a small internal line store, and read data is returned from that store. The block replaces the real DDR2 controller in simulation and in loopback hardware tests, and it flags reads that hit lines which were never written.

---
 rtl/ddr2_if_pkg.sv | 24 ++
 rtl/mem_resp_lfsr8.sv | 31 +++
 rtl/ddr2_mem_responder_model.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ddr2_if_pkg.sv
// Shared definitions for the 256-bit cache-to-DDR2 command link: widths, responder FSM states,
// LFSR constants and the read-miss fill pattern.
package ddr2_if_pkg;

  localparam int unsigned ADDR_W   = 28;
  localparam int unsigned DATA_W   = 256;
  localparam int unsigned LINE_OFS = 3;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp,
    StHold
  } resp_state_e;

  // Miss data: the full command address repeated in every 32-bit word.
  function automatic logic [DATA_W-1:0] fill_pattern(input logic [ADDR_W-1:0] addr);
    return {8{{4'h0, addr}}};
  endfunction

endpackage

// File: rtl/mem_resp_lfsr8.sv
// 8-bit Galois LFSR used to jitter response latency. Advances every cycle.
module mem_resp_lfsr8
  import ddr2_if_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] lfsr
);

  logic [7:0] lfsr_q, lfsr_d;

  // Galois step: shift right, fold the taps in when the outgoing bit is set.
  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_d = (lfsr_q >> 1) ^ LFSR_TAPS;
    end
  end

  // State register, seeded on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/ddr2_mem_responder_model.sv
// Memory-side responder for the cache-to-DDR2 link. Accepts one command at a time, waits a
// programmable latency, pulses ready and commits writes to / serves reads from a small line store.
// Optional build macro: MEM_RESP_RAND_LAT_EN adds 0..7 LFSR-driven cycles to each latency.
module ddr2_mem_responder_model
  import ddr2_if_pkg::*;
#(
  parameter int unsigned RESP_LATENCY = 8,
  parameter int unsigned DEPTH        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   mem_data_wr1,
  input  logic [ADDR_W-1:0]   mem_data_addr1,
  input  logic                mem_rw_data1,
  input  logic                mem_valid_data1,
  output logic                mem_ready_data1,
  output logic [DATA_W-1:0]   mem_data_rd1,
  output logic                miss_rd,
  output logic [15:0]         wr_count,
  output logic [15:0]         rd_count
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned TagW = ADDR_W - LINE_OFS;
  localparam int unsigned CntW = 11;

  resp_state_e       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   lat_total;
  logic              accept;
  logic              commit;

  logic              cmd_rw_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] cmd_wdata_q;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [TagW-1:0]   tag_q  [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  logic              ready_q, miss_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [15:0]       wr_count_q, rd_count_q;

  logic [IdxW-1:0]   idx;
  logic [TagW-1:0]   cmd_tag;
  logic              hit;

`ifdef MEM_RESP_RAND_LAT_EN
  logic [7:0] lfsr;
  logic       unused_lfsr;

  mem_resp_lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  assign unused_lfsr = ^lfsr[7:3];
  assign lat_total   = CntW'(RESP_LATENCY) + CntW'(lfsr[2:0]);
`else
  assign lat_total = CntW'(RESP_LATENCY);
`endif

  assign idx     = cmd_addr_q[LINE_OFS +: IdxW];
  assign cmd_tag = cmd_addr_q[ADDR_W-1:LINE_OFS];
  assign hit     = valid_q[idx] && (tag_q[idx] == cmd_tag);

  // Next-state logic. RESP is the last latency cycle; ready is registered out of it, so the
  // ready-high cycle coincides with HOLD and a held valid is re-accepted every latency+2 edges.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_valid_data1) begin
          accept = 1'b1;
          if (lat_total == CntW'(1)) begin
            state_d = StResp;
          end else begin
            state_d = StBusy;
            cnt_d   = lat_total - CntW'(2);
          end
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        commit  = 1'b1;
        state_d = StHold;
      end
      StHold: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and latency counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Command capture at acceptance; inputs are ignored afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_rw_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
    end else if (accept) begin
      cmd_rw_q    <= mem_rw_data1;
      cmd_addr_q  <= mem_data_addr1;
      cmd_wdata_q <= mem_data_wr1;
    end
  end

  // Line data and tags are not reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (commit && cmd_rw_q) begin
      data_q[idx] <= cmd_wdata_q;
      tag_q[idx]  <= cmd_tag;
    end
  end

  // Line valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (commit && cmd_rw_q) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Response outputs and saturating completion counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q    <= 1'b0;
      miss_q     <= 1'b0;
      rd_data_q  <= '0;
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      ready_q <= commit;
      miss_q  <= commit && !cmd_rw_q && !hit;
      if (commit && !cmd_rw_q) begin
        rd_data_q <= hit ? data_q[idx] : fill_pattern(cmd_addr_q);
        if (rd_count_q != 16'hFFFF) begin
          rd_count_q <= rd_count_q + 16'd1;
        end
      end
      if (commit && cmd_rw_q && (wr_count_q != 16'hFFFF)) begin
        wr_count_q <= wr_count_q + 16'd1;
      end
    end
  end

  assign mem_ready_data1 = ready_q;
  assign miss_rd         = miss_q;
  assign mem_data_rd1    = rd_data_q;
  assign wr_count        = wr_count_q;
  assign rd_count        = rd_count_q;

endmodule
